// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: state encoding,
// instruction classes, ALU codes, mux selects, trap causes and opcode match values.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH, CLS_LOAD,
        CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM
    } class_e;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_SYSCALL = 2'd3;

    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Opcode-field mask and match values for each base instruction group.
    localparam logic [31:0] INST_OPC_MASK = 32'h0000_007F;
    localparam logic [31:0] INST_LUI      = 32'h0000_0037;
    localparam logic [31:0] INST_AUIPC    = 32'h0000_0017;
    localparam logic [31:0] INST_JAL      = 32'h0000_006F;
    localparam logic [31:0] INST_JALR     = 32'h0000_0067;
    localparam logic [31:0] INST_BRANCH   = 32'h0000_0063;
    localparam logic [31:0] INST_LOAD     = 32'h0000_0003;
    localparam logic [31:0] INST_STORE    = 32'h0000_0023;
    localparam logic [31:0] INST_OPIMM    = 32'h0000_0013;
    localparam logic [31:0] INST_OP       = 32'h0000_0033;
    localparam logic [31:0] INST_FENCE    = 32'h0000_000F;
    localparam logic [31:0] INST_SYSTEM   = 32'h0000_0073;

    function automatic logic is_opc(input logic [31:0] ir, input logic [31:0] match);
        return (ir & INST_OPC_MASK) == match;
    endfunction

    // funct3 to ALU code; alt selects SUB/SRA over ADD/SRL.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: IR -> class, ALU op, immediate format, illegal flag.
module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output class_e      cls_o,
    output logic [3:0]  alu_op_o,
    output logic [2:0]  imm_sel_o,
    output logic        illegal_o
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign f3 = ir_i[14:12];
    assign f7 = ir_i[31:25];
    // Register specifiers and immediate bits are the datapath's business.
    assign unused_fields = ^{ir_i[24:15], ir_i[11:7]};

    // Classify the opcode and apply the per-group funct3/funct7 legality rules.
    always_comb begin
        cls_o     = CLS_FENCE;
        alu_op_o  = ALU_ADD;
        imm_sel_o = IMM_I;
        illegal_o = 1'b0;
        if (is_opc(ir_i, INST_LUI)) begin
            cls_o     = CLS_LUI;
            imm_sel_o = IMM_U;
            alu_op_o  = ALU_PASSB;
        end else if (is_opc(ir_i, INST_AUIPC)) begin
            cls_o     = CLS_AUIPC;
            imm_sel_o = IMM_U;
        end else if (is_opc(ir_i, INST_JAL)) begin
            cls_o     = CLS_JAL;
            imm_sel_o = IMM_J;
        end else if (is_opc(ir_i, INST_JALR)) begin
            cls_o     = CLS_JALR;
            illegal_o = (f3 != 3'd0);
        end else if (is_opc(ir_i, INST_BRANCH)) begin
            cls_o     = CLS_BRANCH;
            imm_sel_o = IMM_B;
            illegal_o = (f3 == 3'd2) || (f3 == 3'd3);
        end else if (is_opc(ir_i, INST_LOAD)) begin
            cls_o     = CLS_LOAD;
            illegal_o = (f3 == 3'd3) || (f3[2:1] == 2'b11);
        end else if (is_opc(ir_i, INST_STORE)) begin
            cls_o     = CLS_STORE;
            imm_sel_o = IMM_S;
            illegal_o = f3[2] || (f3[1] && f3[0]);
        end else if (is_opc(ir_i, INST_OPIMM)) begin
            cls_o     = CLS_OPIMM;
            alu_op_o  = alu_from_funct(f3, (f3 == 3'd5) && f7[5]);
            illegal_o = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                        ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
        end else if (is_opc(ir_i, INST_OP)) begin
            cls_o     = CLS_OP;
            alu_op_o  = alu_from_funct(f3, f7[5]);
            illegal_o = !((f7 == 7'h00) ||
                          ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
        end else if (is_opc(ir_i, INST_FENCE)) begin
            cls_o = CLS_FENCE;
        end else if (is_opc(ir_i, INST_SYSTEM)) begin
            cls_o = CLS_SYSTEM;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences the shared ALU datapath and the
// unified memory port, and traps on illegal/system encodings and memory timeouts.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   FETCH     | request instruction at PC; load IR on mem_ready
//   DECODE    | classify IR; trap on illegal encoding or SYSTEM
//   EXECUTE   | ALU computes ALUOut (result, address or branch target)
//   MEM       | load/store access at ALUOut
//   WRITEBACK | update PC and register file, pulse retire
//   TRAP      | everything idle; only reset leaves
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] inst_i,
    input  logic        mem_ready_i,
    input  logic        br_taken_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic [1:0]  mem_size_o,
    output logic        mem_unsigned_o,
    output logic        ir_we_o,
    output logic [2:0]  imm_sel_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        retire_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [2:0]  state_o
);

    localparam bit         TO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;

    class_e      cls;
    logic [3:0]  dec_alu;
    logic [2:0]  dec_imm;
    logic        dec_illegal;
    logic        timeout_hit;

    logic        req, we, addr_sel, uns, irwe, a_sel, b_sel, rfwe, pcwe, pcsel, ret, trp;
    logic [1:0]  size, wb;
    logic [2:0]  imm;
    logic [3:0]  alu;

    multicycle_ctrl_decode u_decode (
        .ir_i      (ir_q),
        .cls_o     (cls),
        .alu_op_o  (dec_alu),
        .imm_sel_o (dec_imm),
        .illegal_o (dec_illegal)
    );

    // The next not-ready cycle would make the wait count reach MEM_TIMEOUT.
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    // State, IR, wait counter and trap cause registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic and per-state control decode.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        size     = 2'd0;
        uns      = 1'b0;
        irwe     = 1'b0;
        imm      = IMM_I;
        alu      = ALU_ADD;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        rfwe     = 1'b0;
        wb       = WB_ALU;
        pcwe     = 1'b0;
        pcsel    = 1'b0;
        ret      = 1'b0;
        trp      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                req  = 1'b1;
                size = SIZE_WORD;
                if (mem_ready_i) begin
                    irwe    = 1'b1;
                    ir_d    = inst_i;
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (cls == CLS_SYSTEM) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_SYSCALL;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                imm     = dec_imm;
                alu     = dec_alu;
                a_sel   = (cls == CLS_AUIPC) || (cls == CLS_JAL) || (cls == CLS_BRANCH);
                b_sel   = !((cls == CLS_OP) || (cls == CLS_FENCE));
                state_d = ((cls == CLS_LOAD) || (cls == CLS_STORE)) ? ST_MEM : ST_WRITEBACK;
            end
            ST_MEM: begin
                req      = 1'b1;
                addr_sel = 1'b1;
                we       = (cls == CLS_STORE);
                size     = ir_q[13:12];
                uns      = ir_q[14];
                if (mem_ready_i) begin
                    state_d = ST_WRITEBACK;
                end else if (timeout_hit) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_WRITEBACK: begin
                pcwe    = 1'b1;
                ret     = 1'b1;
                pcsel   = (cls == CLS_JAL) || (cls == CLS_JALR) ||
                          ((cls == CLS_BRANCH) && br_taken_i);
                rfwe    = !((cls == CLS_BRANCH) || (cls == CLS_STORE) || (cls == CLS_FENCE));
                wb      = (cls == CLS_LOAD) ? WB_MEM :
                          ((cls == CLS_JAL) || (cls == CLS_JALR)) ? WB_PC4 : WB_ALU;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                trp = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        if ((state_d != state_q) || (req && mem_ready_i)) begin
            cnt_d = '0;
        end else if (req) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Reset forces every output low at once, even mid-cycle.
    always_comb begin
        mem_req_o      = req      & ~reset_i;
        mem_we_o       = we       & ~reset_i;
        mem_addr_sel_o = addr_sel & ~reset_i;
        mem_size_o     = reset_i ? 2'd0 : size;
        mem_unsigned_o = uns      & ~reset_i;
        ir_we_o        = irwe     & ~reset_i;
        imm_sel_o      = reset_i ? 3'd0 : imm;
        alu_op_o       = reset_i ? 4'd0 : alu;
        alu_a_sel_o    = a_sel    & ~reset_i;
        alu_b_sel_o    = b_sel    & ~reset_i;
        rf_we_o        = rfwe     & ~reset_i;
        wb_sel_o       = reset_i ? 2'd0 : wb;
        pc_we_o        = pcwe     & ~reset_i;
        pc_sel_o       = pcsel    & ~reset_i;
        retire_o       = ret      & ~reset_i;
        trap_o         = trp      & ~reset_i;
        trap_cause_o   = reset_i ? 2'd0 : cause_q;
        state_o        = reset_i ? 3'd0 : state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and randomized instruction
// streams checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5,
                   K_ST = 6, K_OPI = 7, K_OP = 8, K_FENCE = 9, K_SYS = 10, K_ILL = 11;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       asel;
        logic [1:0] size;
        logic       uns;
        logic       irwe;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       a;
        logic       b;
        logic       rfwe;
        logic [1:0] wb;
        logic       pcwe;
        logic       pcsel;
        logic       ret;
        logic       trap;
        logic [1:0] cause;
        logic [2:0] st;
    } outs_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = '0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;

    logic        mem_req, mem_we, mem_addr_sel, mem_unsigned, ir_we, alu_a_sel, alu_b_sel;
    logic        rf_we, pc_we, pc_sel, retire, trap;
    logic [1:0]  mem_size, wb_sel, trap_cause;
    logic [2:0]  imm_sel, state;
    logic [3:0]  alu_op;

    outs_t obs;
    int    checks = 0;
    int    errors = 0;
    int    retire_seen = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .inst_i         (inst),
        .mem_ready_i    (mem_ready),
        .br_taken_i     (br_taken),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_sel_o (mem_addr_sel),
        .mem_size_o     (mem_size),
        .mem_unsigned_o (mem_unsigned),
        .ir_we_o        (ir_we),
        .imm_sel_o      (imm_sel),
        .alu_op_o       (alu_op),
        .alu_a_sel_o    (alu_a_sel),
        .alu_b_sel_o    (alu_b_sel),
        .rf_we_o        (rf_we),
        .wb_sel_o       (wb_sel),
        .pc_we_o        (pc_we),
        .pc_sel_o       (pc_sel),
        .retire_o       (retire),
        .trap_o         (trap),
        .trap_cause_o   (trap_cause),
        .state_o        (state)
    );

    always #5 clock = ~clock;

    assign obs = {mem_req, mem_we, mem_addr_sel, mem_size, mem_unsigned, ir_we, imm_sel,
                  alu_op, alu_a_sel, alu_b_sel, rf_we, wb_sel, pc_we, pc_sel, retire,
                  trap, trap_cause, state};

    always @(negedge clock) if (retire === 1'b1) retire_seen++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int classify(input logic [31:0] i);
        logic [6:0] opc = i[6:0];
        logic [2:0] f3  = i[14:12];
        logic [6:0] f7  = i[31:25];
        case (opc)
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            7'h6F: return K_JAL;
            7'h67: return (f3 == 0) ? K_JALR : K_ILL;
            7'h63: return (f3 == 2 || f3 == 3) ? K_ILL : K_BR;
            7'h03: return (f3 == 3 || f3 >= 6) ? K_ILL : K_LD;
            7'h23: return (f3 > 2) ? K_ILL : K_ST;
            7'h13: begin
                if (f3 == 1 && f7 != 0) return K_ILL;
                if (f3 == 5 && f7 != 0 && f7 != 7'h20) return K_ILL;
                return K_OPI;
            end
            7'h33: begin
                if (f7 == 0) return K_OP;
                if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) return K_OP;
                return K_ILL;
            end
            7'h0F: return K_FENCE;
            7'h73: return K_SYS;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] ref_alu(input int k, input logic [31:0] i);
        logic [2:0] f3  = i[14:12];
        logic       alt = i[30];
        if (k == K_LUI) return 4'd10;
        if (k != K_OP && k != K_OPI) return 4'd0;
        case (f3)
            3'd0: return (k == K_OP && alt) ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [2:0] ref_imm(input int k);
        if (k == K_LUI || k == K_AUIPC) return 3'd3;
        if (k == K_JAL) return 3'd4;
        if (k == K_BR) return 3'd2;
        if (k == K_ST) return 3'd1;
        return 3'd0;
    endfunction

    function automatic outs_t e_fetch(input logic irwe);
        outs_t e = '0;
        e.req = 1'b1; e.size = 2'd2; e.irwe = irwe; e.st = 3'd0;
        return e;
    endfunction

    function automatic outs_t e_decode();
        outs_t e = '0;
        e.st = 3'd1;
        return e;
    endfunction

    function automatic outs_t e_exec(input logic [31:0] i);
        outs_t e = '0;
        int    k = classify(i);
        e.st  = 3'd2;
        e.imm = ref_imm(k);
        e.alu = ref_alu(k, i);
        e.a   = (k == K_AUIPC || k == K_JAL || k == K_BR);
        e.b   = !(k == K_OP || k == K_FENCE);
        return e;
    endfunction

    function automatic outs_t e_mem(input logic [31:0] i);
        outs_t e = '0;
        e.st = 3'd3; e.req = 1'b1; e.asel = 1'b1;
        e.we = (classify(i) == K_ST);
        e.size = i[13:12]; e.uns = i[14];
        return e;
    endfunction

    function automatic outs_t e_wb(input logic [31:0] i, input logic br);
        outs_t e = '0;
        int    k = classify(i);
        e.st = 3'd4; e.pcwe = 1'b1; e.ret = 1'b1;
        e.pcsel = (k == K_JAL || k == K_JALR || (k == K_BR && br));
        e.rfwe  = !(k == K_BR || k == K_ST || k == K_FENCE);
        e.wb    = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
        return e;
    endfunction

    function automatic outs_t e_trap(input logic [1:0] cause);
        outs_t e = '0;
        e.st = 3'd5; e.trap = 1'b1; e.cause = cause;
        return e;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick_check(input string tag, input outs_t exp);
        @(negedge clock);
        chk(tag, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic rand_inputs();
        mem_ready = 1'($urandom);
        inst      = $urandom;
        br_taken  = 1'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rand_inputs();
        @(negedge clock);
        chk("reset_outputs_zero", '0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Drive one instruction through the controller and check every cycle.
    task automatic run_instr(input logic [31:0] ins, input int wf, input int wm,
                             input logic br, output bit trapped);
        int k = classify(ins);
        for (int w = 0; w <= wf; w++) begin
            mem_ready = (w == wf);
            inst      = (w == wf) ? ins : $urandom;
            br_taken  = 1'($urandom);
            tick_check("fetch", e_fetch(w == wf));
        end
        rand_inputs();
        tick_check("decode", e_decode());
        if (k == K_ILL || k == K_SYS) begin
            for (int c = 0; c < 3; c++) begin
                rand_inputs();
                tick_check("trap_entry", e_trap((k == K_SYS) ? 2'd3 : 2'd1));
            end
            trapped = 1'b1;
            return;
        end
        rand_inputs();
        tick_check("execute", e_exec(ins));
        if (k == K_LD || k == K_ST) begin
            for (int w = 0; w <= wm; w++) begin
                mem_ready = (w == wm);
                inst      = $urandom;
                br_taken  = 1'($urandom);
                tick_check("mem", e_mem(ins));
            end
        end
        mem_ready = 1'($urandom);
        inst      = $urandom;
        br_taken  = br;
        tick_check("writeback", e_wb(ins, br));
        trapped = 1'b0;
    endtask

    function automatic logic [31:0] rand_legal();
        logic [31:0] r  = $urandom;
        logic [2:0]  f3 = r[14:12];
        logic [6:0]  f7 = r[31:25];
        logic [6:0]  opc;
        int          v;
        case ($urandom_range(0, 9))
            0: opc = 7'h37;
            1: opc = 7'h17;
            2: opc = 7'h6F;
            3: begin opc = 7'h67; f3 = 3'd0; end
            4: begin opc = 7'h63; v = $urandom_range(0, 5); f3 = 3'((v >= 2) ? v + 2 : v); end
            5: begin opc = 7'h03; v = $urandom_range(0, 4); f3 = 3'((v >= 3) ? v + 1 : v); end
            6: begin opc = 7'h23; f3 = 3'($urandom_range(0, 2)); end
            7: begin
                opc = 7'h13;
                if (f3 == 3'd1) f7 = 7'h00;
                if (f3 == 3'd5) f7 = r[0] ? 7'h20 : 7'h00;
            end
            8: begin
                opc = 7'h33;
                f7  = ((f3 == 3'd0 || f3 == 3'd5) && r[0]) ? 7'h20 : 7'h00;
            end
            default: opc = 7'h0F;
        endcase
        r[6:0]   = opc;
        r[14:12] = f3;
        r[31:25] = f7;
        return r;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        bit          tr;
        int          r0;
        int          nlegal;
        logic [31:0] w;
        logic [6:0]  opcs [11];

        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

        do_reset();

        // ADD x3,x1,x2 with zero-wait memory; LW with 3 MEM wait cycles
        run_instr(32'h002081B3, 0, 0, 1'b0, tr);
        run_instr(32'h00812283, 0, 3, 1'b0, tr);
        // BEQ taken / not taken
        run_instr(32'h00208463, 0, 0, 1'b1, tr);
        run_instr(32'h00208463, 2, 0, 1'b0, tr);

        // Random legal stream with random wait states below the timeout
        r0     = retire_seen;
        nlegal = 40;
        for (int n = 0; n < nlegal; n++) begin
            run_instr(rand_legal(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                      1'($urandom), tr);
        end
        checks++;
        assert (retire_seen - r0 == nlegal) else begin
            errors++;
            $error("FAIL retire_count observed=%0d expected=%0d", retire_seen - r0, nlegal);
        end

        // Random encodings over valid opcodes with arbitrary funct fields, plus raw words
        for (int n = 0; n < 30; n++) begin
            w = $urandom;
            if (n % 4 != 3) w[6:0] = opcs[$urandom_range(0, 10)];
            run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), tr);
            if (tr) do_reset();
        end

        // Illegal all-ones word: trap stays put with no pc/rf writes
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, tr);
        for (int c = 0; c < 20; c++) begin
            rand_inputs();
            tick_check("illegal_hold", e_trap(2'd1));
        end
        do_reset();

        // ECALL
        run_instr(32'h00000073, 1, 0, 1'b0, tr);
        do_reset();

        // Fetch timeout: TO request cycles, then TRAP with mem_req low
        for (int c = 0; c < TO; c++) begin
            mem_ready = 1'b0;
            inst      = $urandom;
            tick_check("timeout_wait", e_fetch(1'b0));
        end
        for (int c = 0; c < 4; c++) begin
            rand_inputs();
            tick_check("timeout_trap", e_trap(2'd2));
        end
        do_reset();

        // Reset asserted in the middle of a SW memory access
        mem_ready = 1'b1; inst = 32'h0020A023;
        tick_check("sw_fetch", e_fetch(1'b1));
        rand_inputs();
        tick_check("sw_decode", e_decode());
        rand_inputs();
        tick_check("sw_exec", e_exec(32'h0020A023));
        mem_ready = 1'b0;
        @(negedge clock);
        chk("sw_mem", e_mem(32'h0020A023));
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_drop", '0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_hold", '0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mem_ready = 1'b0;
        tick_check("refetch_first_cycle", e_fetch(1'b0));
        run_instr(32'h002081B3, 1, 0, 1'b0, tr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
